// File: rtl/regfile_multiport.sv
// Multi-read-port integer register file with x0 hardwired to zero and a post-reset clear sweep.
// Optional retire trace outputs are enabled with the REGFILE_RVFI_EN macro.
module regfile_multiport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  write,
  output logic                  ready,
  output logic                  write_err
`ifdef REGFILE_RVFI_EN
  ,
  output logic [AW-1:0]         rvfi_rd_addr,
  output logic [XLEN-1:0]       rvfi_rd_wdata
`endif
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   w_ptr_nxt;
  logic            r_write_err;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [XLEN-1:0] w_mem_wdata;
  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The sweep and the writeback port share one memory write path.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_mem_we    = 1'b0;
    w_mem_addr  = rd_addr;
    w_mem_wdata = rd_data;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        if (r_ptr == AW'(NREGS - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_ptr_nxt = r_ptr + AW'(1);
        end
      end
      S_RUN: begin
        w_mem_we = write && (rd_addr != '0);
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_err <= 1'b0;
    end else begin
      r_write_err <= write && (r_state != S_RUN);
    end
  end

  assign ready     = (r_state == S_RUN);
  assign write_err = r_write_err;

  always_comb begin
    rs_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (r_state == S_RUN && rs_addr[i*AW +: AW] != '0) begin
        if (BYPASS != 0 && write && rd_addr == rs_addr[i*AW +: AW]) begin
          rs_data[i*XLEN +: XLEN] = rd_data;
        end else begin
          rs_data[i*XLEN +: XLEN] = r_mem[rs_addr[i*AW +: AW]];
        end
      end
    end
  end

`ifdef REGFILE_RVFI_EN
  // Trace reports what the write path stores, so x0 writes show as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvfi_rd_addr  <= '0;
      rvfi_rd_wdata <= '0;
    end else if (r_state == S_RUN && write) begin
      rvfi_rd_addr  <= rd_addr;
      rvfi_rd_wdata <= (rd_addr == '0) ? '0 : w_mem_wdata;
    end else begin
      rvfi_rd_addr  <= '0;
      rvfi_rd_wdata <= '0;
    end
  end
`endif

endmodule
